route_sequencer: RTL and testbench

- Sequences the line-follower datapath through a multi-turn route delivered as one 16-bit command word from the UART wrapper.
- Gates the forward-speed ramp (go) and injects an override error (err_opn_lp) in place of the IR_intf error at each line break to force a left/right turn.
- Handles debounced bumper stops and buzzer drive.
- Sits between UART_wrapper/IR_intf and the motion controller.

---
 rtl/route_sequencer.sv | 167 ++++++++++++++++
 tb/tb_route_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_sequencer.sv
// Route sequencer: walks the line follower through a multi-turn route word, overriding the
// IR error at each line break to force turns, and stopping on debounced bumper hits.
module route_sequencer #(
   parameter bit                 FAST_SIM = 1'b0,
   parameter logic signed [15:0] TURN_ERR = 16'sh0300
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_vld,
   output logic        cmd_ack,
   input  logic        line_present,
   input  logic        BMPL_n,
   input  logic        BMPR_n,
   output logic        go,
   output logic        err_ovr,
   output logic [15:0] err_opn_lp,
   output logic        buzz,
   output logic        route_done,
   output logic        fault
);

   localparam logic [16:0] DB_LAST  = FAST_SIM ? 17'd15    : 17'd65535;
   localparam logic [25:0] TURN_MIN = FAST_SIM ? 26'd256   : 26'd4194304;
   localparam logic [25:0] TURN_TMO = FAST_SIM ? 26'd4096  : 26'd33554432;
   localparam int unsigned BUZZ_BIT = FAST_SIM ? 3 : 13;
   localparam logic [15:0] ERR_LEFT  = 16'(-TURN_ERR);
   localparam logic [15:0] ERR_RIGHT = TURN_ERR;

   typedef enum logic [2:0] {StIdle, StFollow, StTurn, StBumped, StFault} state_e;

   state_e      r_state, w_state_d;
   logic [13:0] r_route, w_route_d;
   logic [25:0] r_timer, w_timer_d;
   logic        w_ack_d, w_done_d;
   logic        r_lp;
   logic [1:0]  r_bmp_s1, r_bmp_s2, r_bmp_db;
   logic [1:0][16:0] r_db_cnt;
   logic        r_go, r_err_ovr, r_buzz, r_ack, r_done, r_fault;
   logic [15:0] r_err;
   logic        w_lf, w_bump, w_released;
   logic [1:0]  w_code;
   logic [1:0]  w_bmp_raw;
   logic        w_unused_cmd;

   assign w_unused_cmd = ^cmd[15:14];
   assign w_bmp_raw    = {BMPR_n, BMPL_n};
   assign w_lf         = r_lp & ~line_present;
   assign w_bump       = ~r_bmp_db[0] | ~r_bmp_db[1];
   assign w_released   = &r_bmp_db;
   assign w_code       = r_route[1:0];

   // Synchronise each bumper, then accept a new level only after DB_LAST+1 steady cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bmp_s1 <= 2'b11;
         r_bmp_s2 <= 2'b11;
         r_bmp_db <= 2'b11;
         r_db_cnt <= '0;
         r_lp     <= 1'b0;
      end else begin
         r_bmp_s1 <= w_bmp_raw;
         r_bmp_s2 <= r_bmp_s1;
         r_lp     <= line_present;
         for (int i = 0; i < 2; i++) begin
            if (r_bmp_s2[i] == r_bmp_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_bmp_db[i] <= r_bmp_s2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 17'd1;
            end
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_route_d = r_route;
      w_ack_d   = 1'b0;
      w_done_d  = 1'b0;
      unique case (r_state)
         StIdle, StFault: begin
            if (cmd_vld) begin
               w_ack_d   = 1'b1;
               w_route_d = cmd[13:0];
               if (cmd[1:0] == 2'b00) begin
                  w_done_d  = 1'b1;
                  w_state_d = StIdle;
               end else begin
                  w_state_d = StFollow;
               end
            end
         end
         StFollow: begin
            if (w_bump) begin
               w_state_d = StBumped;
            end else if (w_lf) begin
               unique case (w_code)
                  2'b00: begin
                     w_done_d  = 1'b1;
                     w_state_d = StIdle;
                  end
                  2'b01, 2'b10: w_state_d = StTurn;
                  2'b11:        w_route_d = {2'b00, r_route[13:2]};
               endcase
            end
         end
         StTurn: begin
            if (w_bump) begin
               w_state_d = StBumped;
            end else if ((r_timer >= TURN_MIN) && line_present) begin
               w_route_d = {2'b00, r_route[13:2]};
               w_state_d = StFollow;
            end else if (r_timer >= TURN_TMO) begin
               w_state_d = StFault;
            end
         end
         StBumped: begin
            // Route is left untouched so an interrupted turn is retried at the next fall.
            if (w_released) w_state_d = StFollow;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign w_timer_d = (w_state_d != r_state) ? 26'd0 : r_timer + 26'd1;

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_route   <= '0;
         r_timer   <= '0;
         r_go      <= 1'b0;
         r_err_ovr <= 1'b0;
         r_err     <= '0;
         r_buzz    <= 1'b0;
         r_ack     <= 1'b0;
         r_done    <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_route   <= w_route_d;
         r_timer   <= w_timer_d;
         r_go      <= (w_state_d == StFollow) || (w_state_d == StTurn);
         r_err_ovr <= (w_state_d == StTurn);
         r_err     <= (w_state_d != StTurn) ? 16'd0 :
                      (w_route_d[1:0] == 2'b01) ? ERR_LEFT : ERR_RIGHT;
         r_buzz    <= (w_state_d == StFault) ||
                      ((w_state_d == StBumped) && w_timer_d[BUZZ_BIT]);
         r_ack     <= w_ack_d;
         r_done    <= w_done_d;
         r_fault   <= (w_state_d == StFault);
      end
   end

   assign go         = r_go;
   assign err_ovr    = r_err_ovr;
   assign err_opn_lp = r_err;
   assign buzz       = r_buzz;
   assign cmd_ack    = r_ack;
   assign route_done = r_done;
   assign fault      = r_fault;

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer: a route-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_route_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] cmd = 16'h0000;
   logic        cmd_vld = 1'b0;
   logic        line_present = 1'b1;
   logic        BMPL_n = 1'b1;
   logic        BMPR_n = 1'b1;
   logic        cmd_ack, go, err_ovr, buzz, route_done, fault;
   logic [15:0] err_opn_lp;

   int n_chk = 0;
   int n_fail = 0;
   int n_ack = 0;
   int n_done = 0;
   int n_ovr = 0;

   route_sequencer #(
      .FAST_SIM (1'b1),
      .TURN_ERR (16'sh0300)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (cmd),
      .cmd_vld      (cmd_vld),
      .cmd_ack      (cmd_ack),
      .line_present (line_present),
      .BMPL_n       (BMPL_n),
      .BMPR_n       (BMPR_n),
      .go           (go),
      .err_ovr      (err_ovr),
      .err_opn_lp   (err_opn_lp),
      .buzz         (buzz),
      .route_done   (route_done),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: 0 idle, 1 follow, 2 turn, 3 bumped, 4 fault; route kept as a queue of codes.
   int unsigned m_route[$];
   int          m_st = 0, m_nst, m_cnt = 0, m_code;
   bit          m_lpq = 0, m_lf, m_bump;
   bit          ml_s1 = 1, ml_s2 = 1, ml_db = 1, mr_s1 = 1, mr_s2 = 1, mr_db = 1;
   int          ml_run = 0, mr_run = 0;
   logic        m_go = 0, m_ovr = 0, m_buzz = 0, m_ack = 0, m_done = 0, m_fault = 0;
   logic [15:0] m_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_route.delete();
         m_st = 0; m_cnt = 0; m_lpq = 0;
         ml_s1 = 1; ml_s2 = 1; ml_db = 1; ml_run = 0;
         mr_s1 = 1; mr_s2 = 1; mr_db = 1; mr_run = 0;
         m_go = 0; m_ovr = 0; m_err = 0; m_buzz = 0; m_ack = 0; m_done = 0; m_fault = 0;
      end else begin
         m_code = (m_route.size() != 0) ? m_route[0] : 0;
         m_lf   = m_lpq && !line_present;
         m_bump = !ml_db || !mr_db;
         m_nst  = m_st;
         m_ack  = 0;
         m_done = 0;
         case (m_st)
            0, 4: if (cmd_vld) begin
               m_ack = 1;
               m_route.delete();
               for (int i = 0; i < 7; i++) m_route.push_back(int'(cmd[2*i +: 2]));
               if (cmd[1:0] == 2'b00) begin m_done = 1; m_nst = 0; end
               else m_nst = 1;
            end
            1: if (m_bump) m_nst = 3;
               else if (m_lf) begin
                  if (m_code == 0) begin m_done = 1; m_nst = 0; end
                  else if (m_code == 3) void'(m_route.pop_front());
                  else m_nst = 2;
               end
            2: if (m_bump) m_nst = 3;
               else if (m_cnt >= 256 && line_present) begin
                  void'(m_route.pop_front());
                  m_nst = 1;
               end else if (m_cnt >= 4096) m_nst = 4;
            3: if (ml_db && mr_db) m_nst = 1;
            default: m_nst = 0;
         endcase
         m_cnt = (m_nst != m_st) ? 0 : m_cnt + 1;
         m_st  = m_nst;
         if (ml_s2 != ml_db) begin
            ml_run++;
            if (ml_run == 16) begin ml_db = ml_s2; ml_run = 0; end
         end else ml_run = 0;
         if (mr_s2 != mr_db) begin
            mr_run++;
            if (mr_run == 16) begin mr_db = mr_s2; mr_run = 0; end
         end else mr_run = 0;
         ml_s2 = ml_s1; ml_s1 = BMPL_n;
         mr_s2 = mr_s1; mr_s1 = BMPR_n;
         m_lpq = line_present;
         m_code  = (m_route.size() != 0) ? m_route[0] : 0;
         m_go    = (m_st == 1) || (m_st == 2);
         m_ovr   = (m_st == 2);
         m_err   = (m_st != 2) ? 16'h0000 : (m_code == 1) ? 16'hFD00 : 16'h0300;
         m_fault = (m_st == 4);
         m_buzz  = (m_st == 4) || ((m_st == 3) && (((m_cnt / 8) % 2) == 1));
      end
   end

   always @(negedge clk) begin
      check("cyc_go", go, m_go);
      check("cyc_err_ovr", err_ovr, m_ovr);
      check("cyc_err_opn_lp", err_opn_lp, m_err);
      check("cyc_buzz", buzz, m_buzz);
      check("cyc_cmd_ack", cmd_ack, m_ack);
      check("cyc_route_done", route_done, m_done);
      check("cyc_fault", fault, m_fault);
      if (cmd_ack) n_ack++;
      if (route_done) n_done++;
      if (err_ovr) n_ovr++;
   end

   task automatic send_cmd(input logic [15:0] c);
      bit got;
      got = 0;
      cmd = c;
      cmd_vld = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (cmd_ack) got = 1;
      end
      cmd_vld = 1'b0;
      check("cmd_accepted", got, 1);
   endtask

   task automatic turn_break(input logic [15:0] exp_err);
      line_present = 1'b0;
      repeat (10) @(negedge clk);
      check("turn_err_ovr", err_ovr, 1);
      check("turn_err_val", err_opn_lp, exp_err);
      repeat (290) @(negedge clk);
      line_present = 1'b1;
      repeat (20) @(negedge clk);
      check("turn_back_follow", {err_ovr, go}, 2'b01);
   endtask

   task automatic wait_buzz(input logic want, output int n);
      n = 0;
      while (buzz !== want && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) check("buzz_wait_timeout", n, 0);
   endtask

   int ack0, done0, ovr0, n0, n1;
   bit got;

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {go, err_ovr, err_opn_lp, buzz, cmd_ack, route_done, fault}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Route 01,10,01,00
      ack0 = n_ack; done0 = n_done;
      send_cmd(16'h0019);
      repeat (20) @(negedge clk);
      check("r1_go", go, 1);
      turn_break(16'hFD00);
      turn_break(16'h0300);
      turn_break(16'hFD00);
      line_present = 1'b0;
      repeat (5) @(negedge clk);
      check("r1_done_once", n_done - done0, 1);
      check("r1_go_off", go, 0);
      repeat (295) @(negedge clk);
      line_present = 1'b1;
      repeat (10) @(negedge clk);
      check("r1_single_ack", n_ack - ack0, 1);
      check("r1_still_idle", go, 0);

      // Bumper bounce, real bump, then turn timeout
      send_cmd(16'h0005);
      repeat (20) @(negedge clk);
      BMPL_n = 1'b0;
      repeat (10) @(negedge clk);
      BMPL_n = 1'b1;
      repeat (30) @(negedge clk);
      check("bounce_ignored", go, 1);
      BMPL_n = 1'b0;
      repeat (25) @(negedge clk);
      check("bumped_go_off", go, 0);
      wait_buzz(1'b0, n0);
      wait_buzz(1'b1, n0);
      wait_buzz(1'b0, n0);
      wait_buzz(1'b1, n1);
      check("buzz_period", n0 + n1, 16);
      BMPL_n = 1'b1;
      repeat (25) @(negedge clk);
      check("bump_released", {go, buzz}, 2'b10);
      line_present = 1'b0;
      repeat (5000) @(negedge clk);
      check("fault_state", {fault, buzz, go}, 3'b110);
      line_present = 1'b1;
      repeat (5) @(negedge clk);
      send_cmd(16'h0002);
      repeat (2) @(negedge clk);
      check("fault_cleared", {fault, go}, 2'b01);

      // Command held pending while busy
      ack0 = n_ack;
      cmd = 16'h0003;
      cmd_vld = 1'b1;
      repeat (20) @(negedge clk);
      turn_break(16'h0300);
      check("no_ack_while_busy", n_ack - ack0, 0);
      done0 = n_done;
      line_present = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (cmd_ack) got = 1;
      end
      cmd_vld = 1'b0;
      check("pending_ack_after_done", got, 1);
      check("pending_done_once", n_done - done0, 1);
      repeat (295) @(negedge clk);
      line_present = 1'b1;
      repeat (20) @(negedge clk);
      check("new_route_running", go, 1);

      // Straight-through code on route 11,00
      ovr0 = n_ovr;
      line_present = 1'b0;
      repeat (300) @(negedge clk);
      line_present = 1'b1;
      repeat (20) @(negedge clk);
      check("straight_no_override", n_ovr - ovr0, 0);
      check("straight_still_follow", go, 1);
      done0 = n_done;
      line_present = 1'b0;
      repeat (5) @(negedge clk);
      check("straight_done", n_done - done0, 1);
      check("straight_idle", go, 0);
      repeat (10) @(negedge clk);
      line_present = 1'b1;
      repeat (10) @(negedge clk);

      // Bump coincident with a line fall, then reset mid-turn
      send_cmd(16'h0001);
      repeat (20) @(negedge clk);
      BMPL_n = 1'b0;
      repeat (18) @(negedge clk);
      line_present = 1'b0;
      repeat (5) @(negedge clk);
      line_present = 1'b1;
      check("bump_beats_fall", {go, err_ovr}, 2'b00);
      repeat (20) @(negedge clk);
      BMPL_n = 1'b1;
      repeat (25) @(negedge clk);
      check("resume_follow", {go, err_ovr}, 2'b10);
      line_present = 1'b0;
      repeat (10) @(negedge clk);
      check("retry_turn_ovr", err_ovr, 1);
      check("retry_turn_err", err_opn_lp, 16'hFD00);
      #3 rst_n = 1'b0;
      #1 check("async_reset", {go, err_ovr, err_opn_lp, buzz, cmd_ack, route_done, fault}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      line_present = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_after_reset", go, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
